// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: ROB sizing, tag width, requester count default and the CDB->ROB packet.
// Tag 0 is reserved to mean "no broadcast", so tags run 1..ROB_SZ+1.
`ifndef ROB_SZ
`define ROB_SZ 32
`endif
`ifndef CDB_NUM_REQ
`define CDB_NUM_REQ 4
`endif

package cdb_arbiter_pkg;

  localparam int SYS_XLEN    = 32;
  localparam int ROB_TAG_W   = $clog2(`ROB_SZ + 2);
  localparam int CDB_NUM_REQ = `CDB_NUM_REQ;

  typedef logic [ROB_TAG_W-1:0] ROB_TAG;

  typedef struct packed {
    ROB_TAG              rob_tag;
    logic [SYS_XLEN-1:0] v;
  } CDB_ROB_PACKET;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Completion-request / CDB broadcast bundle between the functional units and the arbiter.
// master = FU/branch side driving requests, slave = arbiter driving grants and the bus.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int XLEN    = SYS_XLEN,
  parameter int TAG_W   = ROB_TAG_W
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ*XLEN-1:0]  req_value;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     squash_valid;
  CDB_ROB_PACKET            cdb_rob_packet;
  logic                     cdb_valid;

  modport master (
    output req_valid, req_tag, req_value, squash_valid,
    input  req_ready, cdb_rob_packet, cdb_valid
  );

  modport slave (
    input  req_valid, req_tag, req_value, squash_valid,
    output req_ready, cdb_rob_packet, cdb_valid
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans ptr, ptr+1, ... mod N and grants the first request.
// Zero latency, no state; also usable for RS issue-port arbitration.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest request wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any_grant   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin one-hot req_ready, registered 1-cycle broadcast, squash blocks grants;
// losers stall at their FU. Optional CDB_ARB_STATS_EN adds conflict_count / grant_count.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int XLEN    = SYS_XLEN,
  parameter int TAG_W   = ROB_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  cdb_arbiter_if.slave     bus
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]          conflict_count,
  output logic [NUM_REQ*32-1:0] grant_count
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [TAG_W-1:0]   tag_arr [NUM_REQ];
  logic [XLEN-1:0]    val_arr [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  CDB_ROB_PACKET      pkt_q, pkt_d;
  logic               vld_q, vld_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      tag_arr[i]  = bus.req_tag[i*TAG_W +: TAG_W];
      val_arr[i]  = bus.req_value[i*XLEN +: XLEN];
      eligible[i] = bus.req_valid[i] && (tag_arr[i] != '0) && !bus.squash_valid;
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign bus.req_ready      = grant;
  assign bus.cdb_rob_packet = pkt_q;
  assign bus.cdb_valid      = vld_q;

  always_comb begin
    ptr_d = ptr_q;
    pkt_d = '0;
    vld_d = 1'b0;
    if (any_grant) begin
      ptr_d         = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      pkt_d.rob_tag = tag_arr[grant_idx];
      pkt_d.v       = val_arr[grant_idx];
      vld_d         = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      pkt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      pkt_q <= pkt_d;
      vld_q <= vld_d;
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] conflict_q;
  logic [31:0] grant_cnt_q [NUM_REQ];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_q <= '0;
    end else if (($countones(eligible) > 1) && (conflict_q != '1)) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        grant_cnt_q[g] <= '0;
      end else if (grant[g] && (grant_cnt_q[g] != '1)) begin
        grant_cnt_q[g] <= grant_cnt_q[g] + 32'd1;
      end
    end
    assign grant_count[g*32 +: 32] = grant_cnt_q[g];
  end

  assign conflict_count = conflict_q;
`endif

  // A tag-0 request is an FU bug: it is flagged and left stalled rather than broadcast.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        assert (!(bus.req_valid[i] && (tag_arr[i] == '0)))
          else $warning("cdb_arbiter: requester %0d valid with reserved tag 0, not granted", i);
      end
      assert ($onehot0(grant))
        else $error("cdb_arbiter: multiple grants %b", grant);
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_REQ completing functional units.
- Drives CDB_ROB_PACKET into the ROB, which sets V and complete on the tag match.
- Round-robin grant, one broadcast per cycle, registered output with 1-cycle latency.
- Suppresses grants and clears the bus on squash, so no wrong-path completion reaches the ROB.

Parameters:
- NUM_REQ, 4, number of requesting functional units (2..8).
- XLEN, 32, width of the result value.
- TAG_W, $clog2(`ROB_SZ+2), ROB tag width; tag 0 is reserved to mean "no broadcast".

Ports:
- clock  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  per-FU completion request
- req_tag  input  NUM_REQ*TAG_W  per-FU ROB tag (1..`ROB_SZ+1); slice i = bits [i*TAG_W +: TAG_W]
- req_value  input  NUM_REQ*XLEN  per-FU result value, sliced the same way
- req_ready  output  NUM_REQ  one-hot grant; the request is consumed this cycle
- squash_valid  input  1  mispredict flush from the branch unit
- cdb_rob_packet  output  CDB_ROB_PACKET  {rob_tag, v} to the ROB, RS and map table
- cdb_valid  output  1  registered; high when cdb_rob_packet.rob_tag != 0

Behaviour:
- Reset (async) values:
  - cdb_rob_packet = '0 and cdb_valid = 0.
  - RR pointer = 0, so requester 0 has highest priority first.
  - req_ready = 0.
- Eligibility:
  - eligible[i] = req_valid[i] && req_tag[i] != 0 && !squash_valid.
  - A valid request carrying tag 0 is never granted; assertion fires under simulation.
- Grant (combinational):
  - Scan starts at ptr and proceeds ptr, ptr+1, ... modulo NUM_REQ.
  - The first eligible requester gets req_ready[i] = 1; all others get 0.
  - At most one ready bit is high.
- Requester contract:
  - Hold valid, tag and value stable until ready is seen.
  - Deassert or present a new request on the cycle after ready.
- Pointer update:
  - On a grant to i, ptr <= (i+1) mod NUM_REQ on the next edge.
  - With no grant, ptr holds.
  - Wrap-around: a grant to NUM_REQ-1 sets ptr to 0.
- Output register, on each edge:
  - If a grant occurred: cdb_rob_packet <= {req_tag[g], req_value[g]} and cdb_valid <= 1.
  - Otherwise: cdb_rob_packet <= '0 and cdb_valid <= 0.
  - The broadcast is visible exactly one cycle after req_ready; each packet lasts one cycle.
- Squash:
  - In a cycle with squash_valid = 1: no grants, and the next cycle's output is '0.
  - A packet already on the bus in the squash cycle is not retracted; the ROB squash path clears that entry.
  - ptr is unchanged across a squash.
- Simultaneous requests:
  - All NUM_REQ valid every cycle → grants rotate 0,1,2,3,0,...
  - Worst-case wait is NUM_REQ-1 cycles, so the block is starvation-free.
- No internal buffering: a non-granted request simply stalls at its FU.
- Reset mid-operation: output clears immediately (async); a pending request is re-arbitrated from ptr 0 after reset deasserts.

Optional Feature:
- Macro: CDB_ARB_STATS_EN.
- When defined, adds output conflict_count [31:0]:
  - Increments once per cycle in which more than one eligible request exists.
  - Saturates at 32'hFFFF_FFFF and resets to 0.
- Also adds output grant_count [NUM_REQ*32-1:0]: per-requester saturating grant counters.
- When undefined, neither port nor the counters exist, and arbitration behaviour is identical.

Decomposition:
- Shared sys_defs package / header:
  - CDB_ROB_PACKET typedef (rob_tag: ROB_TAG, v: [XLEN-1:0]) is reused, not redefined.
  - ROB_TAG width and `ROB_SZ stay there.
  - Add `CDB_NUM_REQ as the default for NUM_REQ.
- One natural sub-module, rr_arbiter:
  - Parameter N; inputs req[N], ptr; outputs grant one-hot[N], grant_idx, any_grant.
  - Purely combinational and reusable for RS issue-port arbitration.
- cdb_arbiter owns the pointer, squash gating, output register and optional counters.

Test Plan:
- Reset mid-run:
  - Assert reset with cdb_valid = 1 → cdb_rob_packet = '0 immediately, without waiting for a clock.
  - After release, requests {0,2} valid → grant 0 first.
- Single request:
  - req_valid = 4'b0100, tag 3, value 32'hDEAD_BEEF → req_ready = 4'b0100 same cycle.
  - Next cycle cdb_rob_packet = {3, 32'hDEAD_BEEF}, cdb_valid = 1.
  - Following cycle cdb_valid = 0.
- Full contention, all 4 held valid, tags 1..4:
  - Grants 0,1,2,3,0 on consecutive cycles.
  - CDB tags 1,2,3,4,1 each one cycle later.
- Wrap fairness:
  - ptr = 3, requests {0,3} → grant 3, then grant 0.
- Squash:
  - Requests {1} with squash_valid = 1 → req_ready = 0; next-cycle cdb_rob_packet = '0.
  - The request is granted the cycle after squash deasserts.
- Tag-0 request:
  - req_valid[2] = 1, tag 0 → never granted; others are unaffected; assertion fires.
  - With CDB_ARB_STATS_EN: 3 cycles of a 2-way conflict → conflict_count = 3.
